// File: rtl/mmio_dmem.sv
// Data-port responder for the single-cycle MIPS core: word RAM plus an MMIO page holding
// an output FIFO, a free-running timer and a sticky compare-match interrupt.
module mmio_dmem #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int unsigned AW    = $clog2(RAM_WORDS);
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]  DEPTH = 4'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        SelTx      = 3'd0,
        SelStatus  = 3'd1,
        SelTimer   = 3'd2,
        SelCompare = 3'd3,
        SelIrq     = 3'd4
    } io_sel_e;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] ram_idx;
    logic          is_ram, io_page;
    logic [2:0]    io_sel;
    logic          wr_tx, wr_status, wr_timer, wr_compare, wr_irq;

    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [3:0]    count_q, count_d;
    logic [31:0]   timer_q, timer_d, compare_q, compare_d;
    logic          irq_q, irq_d, ovf_q, ovf_d;
    logic          empty, full, pop, push_ok;
    logic          unused_adr;

    assign unused_adr = ^dataadr[1:0];
    assign ram_idx    = dataadr[AW+1:2];
    assign is_ram     = (dataadr[31:AW+2] == '0);
    assign io_page    = (dataadr[31:16] == 16'hFFFF) && (dataadr[15:5] == 11'd0);
    assign io_sel     = dataadr[4:2];

    assign wr_tx      = memwrite && io_page && (io_sel == SelTx);
    assign wr_status  = memwrite && io_page && (io_sel == SelStatus);
    assign wr_timer   = memwrite && io_page && (io_sel == SelTimer);
    assign wr_compare = memwrite && io_page && (io_sel == SelCompare);
    assign wr_irq     = memwrite && io_page && (io_sel == SelIrq);

    assign empty     = (count_q == 4'd0);
    assign full      = (count_q == DEPTH);
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : fifo_mem[rptr_q];
    assign irq       = irq_q;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push_ok   = wr_tx && (!full || pop);

    always_comb begin
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q + {3'd0, push_ok} - {3'd0, pop};
        timer_d   = wr_timer ? writedata : timer_q + 32'd1;
        compare_d = wr_compare ? writedata : compare_q;
        irq_d     = irq_q;
        ovf_d     = ovf_q;
        if (pop) begin
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
        end
        if (push_ok) begin
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
        end
        // Set beats clear for both sticky flags.
        if (timer_q == compare_q) begin
            irq_d = 1'b1;
        end else if (wr_irq && writedata[0]) begin
            irq_d = 1'b0;
        end
        if (wr_tx && !push_ok) begin
            ovf_d = 1'b1;
        end else if (wr_status && writedata[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (is_ram) begin
            readdata = ram[ram_idx];
        end else if (io_page) begin
            case (io_sel)
                SelStatus:  readdata = {24'd0, count_q, 1'b0, ovf_q, full, empty};
                SelTimer:   readdata = timer_q;
                SelCompare: readdata = compare_q;
                SelIrq:     readdata = {31'd0, irq_q};
                default:    readdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (memwrite && is_ram) begin
            ram[ram_idx] <= writedata;
        end
        if (push_ok) begin
            fifo_mem[wptr_q] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= 4'd0;
            timer_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            compare_q <= compare_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_dmem.sv
// Directed bench for mmio_dmem: RAM, FIFO fill/overflow/drain, timer wrap, compare irq, async reset.
module tb_mmio_dmem;

    localparam logic [31:0] A_TX   = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT = 32'hFFFF_0004;
    localparam logic [31:0] A_TIM  = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
    localparam logic [31:0] A_IRQ  = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata, out_data;
    logic        out_valid, irq;
    logic        out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_dmem #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Store issued from one negedge across the next posedge; returns readdata seen mid-store.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [31:0] during);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        #1 during = readdata;
        @(posedge clk);
        #1 memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        memwrite = 1'b0;
        dataadr  = a;
        #1 d = readdata;
    endtask

    task automatic do_reset;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #3;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        do_reset;
        dataadr = A_TIM;
        #1 v = readdata;
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_timer0: got %h want %h", v, 32'd0); end
        rd(A_TIM, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL rst_timer1: got %h want %h", v, 32'd1); end
        rd(A_STAT, v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL rst_status: got %h want %h", v, 32'h1); end
        rd(A_CMP, v);
        n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_compare: got %h want ffffffff", v); end
        n_tests++; if ({out_valid, irq, out_data} !== 34'd0) begin n_fail++;
            $display("FAIL rst_outputs: got valid=%b irq=%b data=%h want 0", out_valid, irq, out_data); end
    endtask

    task automatic test_ram;
        logic [31:0] v, during;
        wr(32'h54, 32'h11, during);
        wr(32'h54, 32'h7, during);
        n_tests++; if (during !== 32'h11) begin n_fail++; $display("FAIL ram_same_cycle: got %h want %h", during, 32'h11); end
        rd(32'h54, v);
        n_tests++; if (v !== 32'h7) begin n_fail++; $display("FAIL ram_load: got %h want %h", v, 32'h7); end
        rd(A_TX, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", v); end
        rd(32'hFFFF_0020, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", v); end
    endtask

    task automatic test_fifo_fill;
        logic [31:0] v, during;
        do_reset;
        for (int i = 1; i <= 8; i++) wr(A_TX, 32'(i), during);
        rd(A_STAT, v);
        n_tests++; if (v !== 32'h82) begin n_fail++; $display("FAIL fill_status: got %h want %h", v, 32'h82); end
        wr(A_TX, 32'd9, during);
        rd(A_STAT, v);
        n_tests++; if (v !== 32'h86) begin n_fail++; $display("FAIL ovf_status: got %h want %h", v, 32'h86); end
        n_tests++; if (out_data !== 32'd1) begin n_fail++; $display("FAIL ovf_head: got %h want %h", out_data, 32'd1); end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            n_tests++; if (!out_valid || out_data !== 32'(i)) begin n_fail++;
                $display("FAIL drain_%0d: got valid=%b data=%h want %h", i, out_valid, out_data, 32'(i)); end
        end
        @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got valid=%b want 0", out_valid); end
        out_ready = 1'b0;
        wr(A_STAT, 32'h4, during);
        rd(A_STAT, v);
        n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", v, 32'h1); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v, during, exp;
        do_reset;
        for (int i = 1; i <= 8; i++) wr(A_TX, 32'h10 + 32'(i), during);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = A_TX;
        writedata = 32'hAA;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        rd(A_STAT, v);
        n_tests++; if (v !== 32'h82) begin n_fail++; $display("FAIL pushpop_status: got %h want %h", v, 32'h82); end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            if (i > 2) @(negedge clk);
            #1;
            exp = (i == 9) ? 32'hAA : 32'h10 + 32'(i);
            n_tests++; if (!out_valid || out_data !== exp) begin n_fail++;
                $display("FAIL pushpop_drain_%0d: got valid=%b data=%h want %h", i, out_valid, out_data, exp); end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_timer;
        logic [31:0] v, during;
        wr(A_TIM, 32'hFFFF_FFFE, during);
        rd(A_TIM, v);
        n_tests++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_load: got %h want fffffffe", v); end
        rd(A_TIM, v);
        n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_inc: got %h want ffffffff", v); end
        rd(A_TIM, v);
        n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL timer_wrap: got %h want 0", v); end
    endtask

    task automatic test_compare;
        logic [31:0] v, during;
        logic found;
        found = 1'b0;
        do_reset;
        wr(A_CMP, 32'd20, during);
        for (int i = 0; i < 60 && !found; i++) begin
            rd(A_TIM, v);
            if (v == 32'd20) begin
                found = 1'b1;
                n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", irq); end
                @(posedge clk);
                #1;
                n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL cmp_timeout: got no timer==20 want match"); end
        wr(A_IRQ, 32'd1, during);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
        wr(A_CMP, 32'd501, during);
        wr(A_TIM, 32'd500, during);
        rd(A_TIM, v);
        n_tests++; if (v !== 32'd500) begin n_fail++; $display("FAIL cmp_align: got %h want %h", v, 32'd500); end
        wr(A_IRQ, 32'd1, during);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", irq); end
        rd(A_IRQ, v);
        n_tests++; if (v !== 32'd1) begin n_fail++; $display("FAIL irq_reg: got %h want 1", v); end
    endtask

    task automatic test_async_reset;
        logic [31:0] during;
        for (int i = 1; i <= 3; i++) wr(A_TX, 32'hC0 + 32'(i), during);
        n_tests++; if (!out_valid || !irq) begin n_fail++;
            $display("FAIL areset_pre: got valid=%b irq=%b want 1 1", out_valid, irq); end
        @(posedge clk);
        #2;
        dataadr = A_STAT;
        reset   = 1'b0;
        #1;
        n_tests++; if ({out_valid, irq, out_data} !== 34'd0) begin n_fail++;
            $display("FAIL areset_out: got valid=%b irq=%b data=%h want 0", out_valid, irq, out_data); end
        n_tests++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL areset_status: got %h want 1", readdata); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset;
        test_ram;
        test_fifo_fill;
        test_back_to_back;
        test_timer;
        test_compare;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
